// File: rtl/rsa_modexp_ctrl_pkg.sv
// rtl/rsa_modexp_ctrl_pkg.sv - shared types for the modular exponentiation sequencer
package rsa_modexp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL_REQ,
        MUL_WAIT,
        SQR_REQ,
        SQR_WAIT,
        CONV_REQ,
        CONV_WAIT,
        DONE
    } mod_exp_state_t;

    // The bit counter must be able to hold MOD_WIDTH itself.
    function automatic int cnt_width(input int mod_width);
        return $clog2(mod_width + 1);
    endfunction

endpackage

// File: rtl/rsa_modexp_ctrl_if.sv
// rtl/rsa_modexp_ctrl_if.sv - job, result and Montgomery request/response channels
interface rsa_modexp_ctrl_if #(
    parameter int MOD_WIDTH = 256
);
    logic                   i_valid;
    logic                   i_ready;
    logic [4*MOD_WIDTH-1:0] i_in;
    logic                   o_valid;
    logic                   o_ready;
    logic [MOD_WIDTH-1:0]   o_out;
    logic                   m_valid;
    logic                   m_ready;
    logic [3*MOD_WIDTH-1:0] m_in;
    logic                   r_valid;
    logic                   r_ready;
    logic [MOD_WIDTH-1:0]   r_out;

    modport master (
        input  i_valid, i_in, o_ready, m_ready, r_valid, r_out,
        output i_ready, o_valid, o_out, m_valid, m_in, r_ready
    );

    modport slave (
        output i_valid, i_in, o_ready, m_ready, r_valid, r_out,
        input  i_ready, o_valid, o_out, m_valid, m_in, r_ready
    );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// rtl/rsa_modexp_ctrl.sv - right-to-left square-and-multiply sequencer driving a shared Montgomery unit
module rsa_modexp_ctrl
    import rsa_modexp_ctrl_pkg::*;
#(
    parameter int MOD_WIDTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    rsa_modexp_ctrl_if.master  bus
);
    localparam int                CNT_W    = cnt_width(MOD_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(MOD_WIDTH - 1);

    typedef struct packed {
        logic [MOD_WIDTH-1:0] base_mont;
        logic [MOD_WIDTH-1:0] exponent;
        logic [MOD_WIDTH-1:0] modulus;
        logic [MOD_WIDTH-1:0] one_mont;
    } rsa_mod_exp_in_t;

    rsa_mod_exp_in_t      job;
    mod_exp_state_t       state;
    mod_exp_state_t       state_nxt;
    logic [MOD_WIDTH-1:0] sqr;
    logic [MOD_WIDTH-1:0] acc;
    logic [MOD_WIDTH-1:0] exp_sh;
    logic [MOD_WIDTH-1:0] mod_r;
    logic [MOD_WIDTH-1:0] res;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 i_ready;
    logic                 m_valid;
    logic                 r_ready;
    logic                 o_valid;
    logic [3*MOD_WIDTH-1:0] m_in;
    logic                 i_fire;
    logic                 r_fire;

    assign job     = bus.i_in;
    assign cnt_inc = cnt + 1'b1;
    assign i_fire  = bus.i_valid && i_ready;
    assign r_fire  = bus.r_valid && r_ready;

    assign bus.i_ready = i_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_in    = m_in;
    assign bus.r_ready = r_ready;
    assign bus.o_valid = o_valid;
    assign bus.o_out   = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (i_fire)      state_nxt = job.exponent[0] ? MUL_REQ : SQR_REQ;
            MUL_REQ:   if (bus.m_ready) state_nxt = MUL_WAIT;
            MUL_WAIT:  if (r_fire)      state_nxt = (cnt == LAST_BIT) ? CONV_REQ : SQR_REQ;
            SQR_REQ:   if (bus.m_ready) state_nxt = SQR_WAIT;
            // exp_sh[1] is the exponent bit that becomes current after this square.
            SQR_WAIT: begin
                if (r_fire) begin
                    if (exp_sh[1])                  state_nxt = MUL_REQ;
                    else if (cnt_inc == LAST_BIT)   state_nxt = CONV_REQ;
                    else                            state_nxt = SQR_REQ;
                end
            end
            CONV_REQ:  if (bus.m_ready) state_nxt = CONV_WAIT;
            CONV_WAIT: if (r_fire)      state_nxt = DONE;
            DONE:      if (bus.o_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_ready = 1'b0;
        m_valid = 1'b0;
        r_ready = 1'b0;
        o_valid = 1'b0;
        m_in    = '0;
        case (state)
            IDLE:      i_ready = 1'b1;
            MUL_REQ: begin
                m_valid = 1'b1;
                m_in    = {acc, sqr, mod_r};
            end
            SQR_REQ: begin
                m_valid = 1'b1;
                m_in    = {sqr, sqr, mod_r};
            end
            // Multiplying by plain 1 strips the R factor from the accumulator.
            CONV_REQ: begin
                m_valid = 1'b1;
                m_in    = {acc, MOD_WIDTH'(1), mod_r};
            end
            MUL_WAIT, SQR_WAIT, CONV_WAIT: r_ready = 1'b1;
            DONE:      o_valid = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sqr    <= '0;
            acc    <= '0;
            exp_sh <= '0;
            mod_r  <= '0;
            res    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_fire) begin
                        sqr    <= job.base_mont;
                        acc    <= job.one_mont;
                        exp_sh <= job.exponent;
                        mod_r  <= job.modulus;
                        cnt    <= '0;
                    end
                end
                MUL_WAIT: if (r_fire) acc <= bus.r_out;
                SQR_WAIT: begin
                    if (r_fire) begin
                        sqr    <= bus.r_out;
                        exp_sh <= exp_sh >> 1;
                        cnt    <= cnt_inc;
                    end
                end
                CONV_WAIT: if (r_fire) res <= bus.r_out;
                default: ;
            endcase
        end
    end

endmodule
